nf10_learning_port_lookup: RTL and testbench
============================================

// Module: nf10_learning_port_lookup
// PURPOSE
//  Learning-switch output-port lookup. Sits directly upstream of the BRAM output queues and feeds their slave AXI-Stream.
//  Per packet, learns the source MAC against the ingress port and looks up the destination MAC in a small register CAM.
//  Writes the one-hot egress bitmap into tuser[31:24]. The output queues fan the packet out on that bitmap.
// PARAMETERS
//  C_DATA_WIDTH   256  tdata width; tstrb = C_DATA_WIDTH/8
//  C_TUSER_WIDTH  128  tuser width; [15:0] len, [23:16] src port, [31:24] dst port, one-hot
//  C_TBL_DEPTH    16   MAC table entries, power of 2, 2..64
// PORTS
//  axi_aclk       in   1      clock
//  axi_reset      in   1      reset, asynchronous, active-high
//  s_axis_tdata   in   256    ingress data; frame byte 0 at [7:0]
//  s_axis_tstrb   in   32     ingress byte strobes
//  s_axis_tuser   in   128    ingress metadata
//  s_axis_tvalid  in   1      ingress valid
//  s_axis_tready  out  1      ingress ready
//  s_axis_tlast   in   1      ingress end of packet
//  m_axis_tdata   out  256    egress to output queues
//  m_axis_tstrb   out  32     egress byte strobes
//  m_axis_tuser   out  128    egress metadata; [31:24] overwritten on first beat only
//  m_axis_tvalid  out  1      egress valid
//  m_axis_tready  in   1      egress ready
//  m_axis_tlast   out  1      egress end of packet
// BEHAVIOUR
//  Clock and reset: one clock, axi_aclk; axi_reset asynchronous, active-high.
//  Reset values: FSM=IDLE, m_axis_tvalid=0, s_axis_tready=0 while reset is asserted, header register=0.
//    All table valid bits=0, replacement pointer=0.
//  Field extraction: DA = bytes 0-5 = tdata[47:0]; SA = bytes 6-11 = tdata[95:48]; src = tuser[23:16].
//    A MAC is multicast/broadcast when byte0 bit0 = 1 (DA[0]).
//  FSM states:
//    IDLE: s_tready=1, m_tvalid=0. When s_tvalid=1, capture the beat into the header register and go to LOOKUP.
//    LOOKUP: s_tready=0. Compare DA and SA in parallel against all valid entries, using the table as it stood before this cycle.
//      Register the result. Perform the learn write at the clock edge. Go to HDR.
//    HDR: m_axis = header register, tuser[31:24] replaced by dst, m_tvalid=1, s_tready=0.
//      On m_tready: go to IDLE if the header beat had tlast, else go to PASS.
//    PASS: combinational pass-through, m_axis_* = s_axis_*, s_tready = m_tready. On s_tvalid & m_tready & s_tlast, go to IDLE.
//  Latency: the first beat appears on m_axis on the 2nd cycle after it is accepted. Remaining beats have zero latency.
//    Overhead is 2 bubbles per packet.
//  dst rules (MAC_MASK = 8'h55, the four MAC ports; DMA bits are never flooded):
//    - DA multicast, or DA miss: dst = MAC_MASK & ~src.
//    - DA hit on port P, P != src: dst = P.
//    - DA hit on port P, P == src: dst = 8'h00. The packet is still forwarded; the output queues drop it.
//  Learning, in the LOOKUP cycle:
//    - SA multicast, or src not one-hot: no write.
//    - SA hit: overwrite that entry's port (port move).
//    - SA miss: write {SA, src, valid} at the pointer, then pointer = pointer+1 mod C_TBL_DEPTH.
//      Full table: round-robin overwrite of the oldest slot.
//  Same packet with DA == SA: lookup sees the pre-write table, so the first such packet floods.
//  Backpressure: HDR holds all m_axis fields stable until m_tready. No beat is dropped or duplicated.
//  Reset mid-packet: FSM returns to IDLE and the table is cleared. The upstream is responsible for discarding the partial packet.
// STRUCTURE
//  Shared package nf10_switch_pkg:
//    - TUSER_LEN/SRC/DST bit offsets
//    - MAC_MASK = 8'h55
//    - ETH_DA_LSB = 0, ETH_SA_LSB = 48
//    - FSM state encoding IDLE/LOOKUP/HDR/PASS
//  Sub-module mac_cam_lite:
//    - C_TBL_DEPTH x {48b MAC, 8b port, valid} registers
//    - two combinational match ports (DA, SA) returning hit + port + index
//    - one write port, with the round-robin pointer held inside
//  The top holds the FSM, the header register, the dst computation and the AXIS muxing.
// TESTING
//  1. Reset, then a 1-beat pkt DA=ff..ff, SA=00:11:22:33:44:55, src=8'h01
//     -> dst=8'h54; table entry 0 = {SA, 8'h01}.
//  2. After test 1: DA=00:11:22:33:44:55 from src=8'h04
//     -> dst=8'h01; first beat out exactly 2 cycles after acceptance.
//  3. After test 1: DA=00:11:22:33:44:55 from src=8'h01 -> dst=8'h00. Then the same SA arrives from src=8'h10
//     -> next DA lookup gives dst=8'h10, and no new entry is allocated.
//  4. 17 distinct unicast SAs from src=8'h01
//     -> the 17th overwrites slot 0; a DA equal to the 1st SA floods (dst=8'h54).
//  5. 4-beat pkt with m_tready toggled 1010.. and random s_tvalid gaps
//     -> output beats are bit-identical except tuser[31:24] on beat 0; tlast on beat 3 only.
//  6. axi_reset asserted during PASS of a 3-beat pkt
//     -> m_tvalid=0 immediately; after release the next pkt to an earlier-learned DA floods.

Source files
------------

// File: rtl/nf10_switch_pkg.sv
// Shared switch definitions: AXIS tuser field offsets, Ethernet field offsets, MAC port mask
// and the lookup FSM state encoding.
package nf10_switch_pkg;

   localparam int TUSER_LEN_LSB = 0;
   localparam int TUSER_SRC_LSB = 16;
   localparam int TUSER_DST_LSB = 24;

   localparam logic [7:0] MAC_MASK = 8'h55;

   localparam int ETH_DA_LSB = 0;
   localparam int ETH_SA_LSB = 48;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_HDR    = 2'd2,
      ST_PASS   = 2'd3
   } lookup_state_t;

   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

endpackage

// File: rtl/mac_cam_lite.sv
// Register CAM of {MAC, port, valid}: two combinational match ports (DA, SA) and one write port.
// A write either moves an existing entry's port or allocates at the round-robin pointer.
module mac_cam_lite #(
   parameter  int C_TBL_DEPTH = 16,
   localparam int IDX_W       = $clog2(C_TBL_DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [47:0]      i_da_mac,
   output logic             o_da_hit,
   output logic [7:0]       o_da_port,
   input  logic [47:0]      i_sa_mac,
   output logic             o_sa_hit,
   output logic [IDX_W-1:0] o_sa_idx,
   input  logic             i_wr_en,
   input  logic             i_wr_hit,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [47:0]      i_wr_mac,
   input  logic [7:0]       i_wr_port
);

   logic [47:0]            r_mac  [C_TBL_DEPTH];
   logic [7:0]             r_port [C_TBL_DEPTH];
   logic [C_TBL_DEPTH-1:0] r_vld;
   logic [IDX_W-1:0]       r_ptr;

   always_comb begin
      o_da_hit  = 1'b0;
      o_da_port = 8'h00;
      o_sa_hit  = 1'b0;
      o_sa_idx  = '0;
      for (int i = 0; i < C_TBL_DEPTH; i++) begin
         if (r_vld[i] && (r_mac[i] == i_da_mac)) begin
            o_da_hit  = 1'b1;
            o_da_port = r_port[i];
         end
         if (r_vld[i] && (r_mac[i] == i_sa_mac)) begin
            o_sa_hit = 1'b1;
            o_sa_idx = IDX_W'(i);
         end
      end
   end

   // The pointer only advances on allocation, so when the table is full it always names the oldest slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld <= '0;
         r_ptr <= '0;
         for (int i = 0; i < C_TBL_DEPTH; i++) begin
            r_mac[i]  <= '0;
            r_port[i] <= '0;
         end
      end else if (i_wr_en) begin
         if (i_wr_hit) begin
            r_port[i_wr_idx] <= i_wr_port;
         end else begin
            r_mac[r_ptr]  <= i_wr_mac;
            r_port[r_ptr] <= i_wr_port;
            r_vld[r_ptr]  <= 1'b1;
            r_ptr         <= r_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/nf10_learning_port_lookup.sv
// Learning-switch port lookup: holds the header beat for one LOOKUP cycle, writes the egress bitmap
// into tuser[31:24] of beat 0 and passes later beats straight through; 2 bubbles per packet.
module nf10_learning_port_lookup
   import nf10_switch_pkg::*;
#(
   parameter int C_DATA_WIDTH  = 256,
   parameter int C_TUSER_WIDTH = 128,
   parameter int C_TBL_DEPTH   = 16
) (
   input  logic                      axi_aclk,
   input  logic                      axi_reset,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast
);

   localparam int IDX_W = $clog2(C_TBL_DEPTH);

   lookup_state_t r_state, w_state_nxt;

   logic [C_DATA_WIDTH-1:0]   r_hdr_tdata;
   logic [C_DATA_WIDTH/8-1:0] r_hdr_tstrb;
   logic [C_TUSER_WIDTH-1:0]  r_hdr_tuser;
   logic                      r_hdr_tlast;
   logic [7:0]                r_dst;

   logic [47:0]               w_da, w_sa;
   logic [7:0]                w_src, w_dst, w_da_port;
   logic                      w_da_hit, w_sa_hit, w_learn;
   logic [IDX_W-1:0]          w_sa_idx;
   logic [C_TUSER_WIDTH-1:0]  w_hdr_tuser;

   assign w_da    = r_hdr_tdata[ETH_DA_LSB +: 48];
   assign w_sa    = r_hdr_tdata[ETH_SA_LSB +: 48];
   assign w_src   = r_hdr_tuser[TUSER_SRC_LSB +: 8];
   assign w_learn = (r_state == ST_LOOKUP) && !w_sa[0] && is_onehot8(w_src);

   mac_cam_lite #(.C_TBL_DEPTH(C_TBL_DEPTH)) u_cam (
      .i_clk     (axi_aclk),
      .i_rst     (axi_reset),
      .i_da_mac  (w_da),
      .o_da_hit  (w_da_hit),
      .o_da_port (w_da_port),
      .i_sa_mac  (w_sa),
      .o_sa_hit  (w_sa_hit),
      .o_sa_idx  (w_sa_idx),
      .i_wr_en   (w_learn),
      .i_wr_hit  (w_sa_hit),
      .i_wr_idx  (w_sa_idx),
      .i_wr_mac  (w_sa),
      .i_wr_port (w_src)
   );

   // A hit back onto the ingress port yields an empty bitmap; the output queues discard it.
   always_comb begin
      w_dst = MAC_MASK & ~w_src;
      if (!w_da[0] && w_da_hit)
         w_dst = (w_da_port == w_src) ? 8'h00 : w_da_port;
   end

   always_comb begin
      w_hdr_tuser                        = r_hdr_tuser;
      w_hdr_tuser[TUSER_DST_LSB +: 8]    = r_dst;
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         r_state     <= ST_IDLE;
         r_hdr_tdata <= '0;
         r_hdr_tstrb <= '0;
         r_hdr_tuser <= '0;
         r_hdr_tlast <= 1'b0;
         r_dst       <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && s_axis_tvalid) begin
            r_hdr_tdata <= s_axis_tdata;
            r_hdr_tstrb <= s_axis_tstrb;
            r_hdr_tuser <= s_axis_tuser;
            r_hdr_tlast <= s_axis_tlast;
         end
         if (r_state == ST_LOOKUP)
            r_dst <= w_dst;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = r_hdr_tdata;
      m_axis_tstrb  = r_hdr_tstrb;
      m_axis_tuser  = w_hdr_tuser;
      m_axis_tlast  = r_hdr_tlast;
      case (r_state)
         ST_IDLE: begin
            s_axis_tready = !axi_reset;
            if (s_axis_tvalid)
               w_state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: w_state_nxt = ST_HDR;
         ST_HDR: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready)
               w_state_nxt = r_hdr_tlast ? ST_IDLE : ST_PASS;
         end
         ST_PASS: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tstrb  = s_axis_tstrb;
            m_axis_tuser  = s_axis_tuser;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_nf10_learning_port_lookup.sv
// Scoreboarded bench for the learning port lookup: expected beats are queued as stimulus is driven
// and checked by a monitor on the falling clock edge.
module tb_nf10_learning_port_lookup;

   localparam int DW = 256;
   localparam int SW = 32;
   localparam int UW = 128;

   localparam logic [47:0] BCAST  = 48'hffff_ffff_ffff;
   localparam logic [47:0] SA_MC  = 48'h0000_0000_0001;
   localparam logic [47:0] MAC_A  = 48'h5544_3322_1100; // 00:11:22:33:44:55
   localparam logic [47:0] MAC_B  = 48'h0000_0000_b002;
   localparam logic [47:0] MAC_C  = 48'h0000_0000_c002;
   localparam logic [47:0] MAC_D  = 48'h0000_0000_d002;
   localparam logic [47:0] MAC_E  = 48'h0000_0000_e002;
   localparam logic [47:0] MAC_F  = 48'h0000_0000_f002;
   localparam logic [47:0] MAC_G  = 48'h0000_0001_0002;
   localparam logic [47:0] MAC_H  = 48'h0000_0002_0002;
   localparam logic [47:0] MAC_J  = 48'h0000_0003_0002;
   localparam logic [47:0] MAC_K  = 48'h0000_0004_0002;

   logic          axi_aclk = 1'b0;
   logic          axi_reset = 1'b1;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [SW-1:0] s_axis_tstrb = '0;
   logic [UW-1:0] s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [SW-1:0] m_axis_tstrb;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      logic          l;
      logic          first;
   } beat_t;

   beat_t sb[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int out_cyc = 0;
   int rdy_mode = 0;   // 0: always ready, 1: toggle every cycle, 2: hold low

   beat_t         mon_e;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic [SW-1:0] prev_s;
   logic [UW-1:0] prev_u;
   logic          prev_l;

   nf10_learning_port_lookup dut (
      .axi_aclk      (axi_aclk),
      .axi_reset     (axi_reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 axi_aclk = ~axi_aclk;

   initial forever begin
      @(posedge axi_aclk);
      cyc++;
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge axi_aclk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   initial forever begin
      @(negedge axi_aclk);
      if (axi_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            vectors++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tstrb !== prev_s ||
                m_axis_tuser !== prev_u || m_axis_tlast !== prev_l) begin
               miscompares++;
               $display("FAIL hold_stable: valid=%b tuser=%h last=%b, required valid=1 tuser=%h last=%b",
                        m_axis_tvalid, m_axis_tuser, m_axis_tlast, prev_u, prev_l);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_beat: tuser=%h last=%b, required no beat", m_axis_tuser, m_axis_tlast);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.first) out_cyc = cyc;
               if (m_axis_tdata !== mon_e.d || m_axis_tstrb !== mon_e.s ||
                   m_axis_tuser !== mon_e.u || m_axis_tlast !== mon_e.l) begin
                  miscompares++;
                  $display("FAIL beat: got tdata=%h tstrb=%h tuser=%h last=%b, required tdata=%h tstrb=%h tuser=%h last=%b",
                           m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast,
                           mon_e.d, mon_e.s, mon_e.u, mon_e.l);
               end
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_d = m_axis_tdata;
         prev_s = m_axis_tstrb;
         prev_u = m_axis_tuser;
         prev_l = m_axis_tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [47:0] mk_sa(input int i);
      return {24'h0a0b0c, 8'(i), 16'h0002};
   endfunction

   // Drives the first nsend beats of an nb-beat packet; beat 0 expects tuser[31:24] = dst.
   task automatic send_pkt(input logic [47:0] da, input logic [47:0] sa, input logic [7:0] src,
                           input int nb, input int nsend, input logic [7:0] dst, input int maxgap);
      beat_t b, e;
      int n;
      for (int i = 0; i < nsend; i++) begin
         b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         b.u = {$urandom, $urandom, $urandom, $urandom};
         if (i == 0) begin
            b.d[47:0]  = da;
            b.d[95:48] = sa;
            b.u[23:16] = src;
         end
         b.s     = (i == nb - 1) ? 32'h0000_ffff : 32'hffff_ffff;
         b.l     = (i == nb - 1);
         b.first = (i == 0);
         e = b;
         if (i == 0) e.u[31:24] = dst;
         if (maxgap > 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, maxgap)) begin
               @(posedge axi_aclk);
               #1;
            end
         end
         s_axis_tdata  = b.d;
         s_axis_tstrb  = b.s;
         s_axis_tuser  = b.u;
         s_axis_tlast  = b.l;
         s_axis_tvalid = 1'b1;
         sb.push_back(e);
         n = 0;
         forever begin
            @(negedge axi_aclk);
            if (s_axis_tready) begin
               if (i == 0) acc_cyc = cyc;
               break;
            end
            n++;
            if (n > 100) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", i, n);
               break;
            end
         end
         @(posedge axi_aclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge axi_aclk);
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic do_reset();
      sb.delete();
      s_axis_tvalid = 1'b0;
      axi_reset = 1'b1;
      repeat (3) @(posedge axi_aclk);
      #1;
      axi_reset = 1'b0;
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (m_axis_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_m_tvalid: got %b, required 0", m_axis_tvalid);
      end
      vectors++;
      if (s_axis_tready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_s_tready: got %b, required 0", s_axis_tready);
      end
      repeat (3) @(posedge axi_aclk);
      #1;
      axi_reset = 1'b0;
      #1;
      vectors++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: s_tready=%b m_tvalid=%b, required 1 and 0", s_axis_tready, m_axis_tvalid);
      end
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic test_flood_bcast();
      send_pkt(BCAST, MAC_A, 8'h01, 1, 1, 8'h54, 0);
      wait_drain();
   endtask

   task automatic test_hit_latency();
      send_pkt(MAC_A, MAC_B, 8'h04, 1, 1, 8'h01, 0);
      wait_drain();
      vectors++;
      if (out_cyc - acc_cyc !== 2) begin
         miscompares++;
         $display("FAIL first_beat_latency: got %0d cycles, required 2", out_cyc - acc_cyc);
      end
   endtask

   task automatic test_port_move();
      send_pkt(MAC_A, MAC_C, 8'h01, 1, 1, 8'h00, 0);
      send_pkt(BCAST, MAC_A, 8'h10, 1, 1, 8'h45, 0);
      send_pkt(MAC_A, MAC_D, 8'h04, 1, 1, 8'h10, 0);
      wait_drain();
   endtask

   task automatic test_learn_rules();
      send_pkt(MAC_E, MAC_E, 8'h02, 1, 1, 8'h55, 0);
      send_pkt(MAC_E, MAC_F, 8'h40, 1, 1, 8'h02, 0);
      send_pkt(BCAST, MAC_G, 8'h03, 1, 1, 8'h54, 0);
      send_pkt(MAC_G, SA_MC, 8'h04, 1, 1, 8'h51, 0);
      wait_drain();
   endtask

   task automatic test_table_wrap();
      do_reset();
      for (int i = 0; i < 17; i++)
         send_pkt(BCAST, mk_sa(i), 8'h01, 1, 1, 8'h54, 0);
      send_pkt(mk_sa(1), SA_MC, 8'h04, 1, 1, 8'h01, 0);
      send_pkt(mk_sa(16), SA_MC, 8'h04, 1, 1, 8'h01, 0);
      send_pkt(mk_sa(0), SA_MC, 8'h01, 1, 1, 8'h54, 0);
      wait_drain();
   endtask

   task automatic test_backpressure();
      rdy_mode = 1;
      send_pkt(BCAST, MAC_H, 8'h01, 4, 4, 8'h54, 3);
      wait_drain();
      rdy_mode = 0;
   endtask

   task automatic test_back_to_back();
      rdy_mode = 1;
      for (int i = 0; i < 4; i++)
         send_pkt(BCAST, mk_sa(40 + i), 8'h04, 1 + i, 1 + i, 8'h51, 0);
      wait_drain();
      rdy_mode = 0;
   endtask

   task automatic test_reset_mid_pkt();
      rdy_mode = 0;
      send_pkt(BCAST, MAC_J, 8'h04, 3, 2, 8'h51, 0);
      rdy_mode = 2;
      @(posedge axi_aclk);
      #2;
      s_axis_tdata  = {8{$urandom}};
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      #1;
      vectors++;
      if (m_axis_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_through_valid: got %b, required 1", m_axis_tvalid);
      end
      axi_reset = 1'b1;
      #1;
      vectors++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_pkt: m_tvalid=%b s_tready=%b, required 0 and 0", m_axis_tvalid, s_axis_tready);
      end
      repeat (2) @(posedge axi_aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      rdy_mode = 0;
      #1;
      axi_reset = 1'b0;
      @(posedge axi_aclk);
      #1;
      wait_drain();
      send_pkt(MAC_J, MAC_K, 8'h01, 1, 1, 8'h54, 0);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_flood_bcast();
      test_hit_latency();
      test_port_move();
      test_learn_rules();
      test_table_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_pkt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
